// File: rtl/inst_queue.sv
// inst_queue: decoupling FIFO between instruction fetch and decode.
// Holds {pc, inst} pairs in a circular buffer; a redirect (flush) or reset
// discards every buffered entry.
// Optional build macro INST_QUEUE_BYPASS_EN: when the queue is empty, an
// incoming entry is presented to decode in the same cycle and is only stored
// if decode does not take it.

// Protocol checker: occupancy stays within 0..DEPTH.
module inst_queue_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk_i,
  input logic          rst_i,
  input logic [CW-1:0] count_i,
  input logic          wr_en_i,
  input logic          rd_en_i
);

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    count_i <= CW'(DEPTH));

  a_no_write_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(wr_en_i && (count_i == CW'(DEPTH))));

  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(rd_en_i && (count_i == CW'(0))));

endmodule

module inst_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 64,
  parameter int INST_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [INST_W-1:0]          in_inst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [INST_W-1:0]          out_inst,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PC_W-1:0]   pc_mem_q   [DEPTH];
  logic [INST_W-1:0] inst_mem_q [DEPTH];

  logic stored_valid_s;
  logic push_s;
  logic pop_s;
  logic wr_en_s;
  logic rd_en_s;
`ifdef INST_QUEUE_BYPASS_EN
  logic bypass_s;
`endif

  // Handshake, head selection and which side of the buffer moves this cycle.
  always_comb begin
    in_ready       = (count_q != CW'(DEPTH)) && !flush && !rst;
    stored_valid_s = (count_q != CW'(0)) && !flush && !rst;
    push_s         = in_valid && in_ready;
`ifdef INST_QUEUE_BYPASS_EN
    bypass_s  = (count_q == CW'(0)) && in_valid && !flush && !rst;
    out_valid = stored_valid_s || bypass_s;
    if (bypass_s) begin
      out_pc   = in_pc;
      out_inst = in_inst;
    end else begin
      out_pc   = pc_mem_q[rd_ptr_q];
      out_inst = inst_mem_q[rd_ptr_q];
    end
    pop_s = out_valid && out_ready;
    // A bypassed entry taken by decode never touches the buffer.
    wr_en_s = push_s && !(bypass_s && out_ready);
    rd_en_s = pop_s && !bypass_s;
`else
    out_valid = stored_valid_s;
    out_pc    = pc_mem_q[rd_ptr_q];
    out_inst  = inst_mem_q[rd_ptr_q];
    pop_s     = out_valid && out_ready;
    wr_en_s   = push_s;
    rd_en_s   = pop_s;
`endif
    count = count_q;
  end

  // Next-state pointers and occupancy; count moves by at most one per cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, rd_en_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State register: reset beats flush, flush beats any push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
    end else if (flush) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are not reset, write enable already excludes flush/reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      pc_mem_q[wr_ptr_q]   <= in_pc;
      inst_mem_q[wr_ptr_q] <= in_inst;
    end
  end

  inst_queue_chk #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_chk (
    .clk_i   (clk),
    .rst_i   (rst),
    .count_i (count_q),
    .wr_en_i (wr_en_s),
    .rd_en_i (rd_en_s)
  );

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue with a scoreboard: stimulus queues the
// entries it expects decode to receive, a monitor pops and compares them
// whenever the queue hands an entry to decode.
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  count;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(4), .PC_W(64), .INST_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .count     (count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every entry handed to decode must be the oldest expected one.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      ent_t e;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual_pc=0x%0h expected=none", out_pc);
      end else begin
        e = sb.pop_front();
        chk("out_pc", out_pc, e.pc);
        chk("out_inst", {32'h0, out_inst}, {32'h0, e.inst});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [63:0] pc, input logic [31:0] inst);
    in_valid = v;
    in_pc    = pc;
    in_inst  = inst;
  endtask

  // Push one entry that the queue is known to accept this cycle.
  task automatic push_ok(input logic [63:0] pc, input logic [31:0] inst);
    ent_t e;
    set_in(1'b1, pc, inst);
    e.pc   = pc;
    e.inst = inst;
    sb.push_back(e);
    @(negedge clk);
    chk("push_in_ready", {63'h0, in_ready}, 64'h1);
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] insts [4];
    insts[0] = 32'h13; insts[1] = 32'h93; insts[2] = 32'h113; insts[3] = 32'h193;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    set_in(1'b1, 64'h8000_0000, 32'h13);

    // Reset held two cycles with in_valid high.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_in_ready", {63'h0, in_ready}, 64'h0);
      chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
      cyc();
    end
    rst = 1'b0;
    set_in(1'b0, 64'h0, 32'h0);
    @(negedge clk);
    chk("post_rst_count", {61'h0, count}, 64'h0);
    chk("post_rst_in_ready", {63'h0, in_ready}, 64'h1);
    chk("post_rst_out_valid", {63'h0, out_valid}, 64'h0);
    cyc();

    // Fill to DEPTH, then try a fifth push.
    for (int i = 0; i < 4; i++) push_ok(64'h8000_0000 + 64'(4 * i), insts[i]);
    set_in(1'b1, 64'h8000_0010, 32'h213);
    @(negedge clk);
    chk("full_count", {61'h0, count}, 64'h4);
    chk("full_in_ready", {63'h0, in_ready}, 64'h0);
    chk("full_out_valid", {63'h0, out_valid}, 64'h1);
    cyc();
    set_in(1'b0, 64'h0, 32'h0);
    @(negedge clk);
    chk("full_count_hold", {61'h0, count}, 64'h4);
    cyc();

    // Drain in order.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain_count", {61'h0, count}, 64'(4 - i));
      cyc();
    end
    @(negedge clk);
    chk("drained_count", {61'h0, count}, 64'h0);
    chk("drained_out_valid", {63'h0, out_valid}, 64'h0);
    cyc();

    // Wrap: hold count at 2 across ten push+pop pairs.
    out_ready = 1'b0;
    push_ok(64'h8000_0020, 32'h1000_0001);
    push_ok(64'h8000_0024, 32'h1000_0002);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ent_t e;
      set_in(1'b1, 64'h8000_0028 + 64'(4 * i), 32'h2000_0000 + 32'(i));
      e.pc = in_pc; e.inst = in_inst;
      sb.push_back(e);
      @(negedge clk);
      chk("wrap_count", {61'h0, count}, 64'h2);
      cyc();
    end
    set_in(1'b0, 64'h0, 32'h0);
    cyc(); cyc();
    @(negedge clk);
    chk("wrap_end_count", {61'h0, count}, 64'h0);
    cyc();

    // Flush with three entries and a competing push.
    out_ready = 1'b0;
    push_ok(64'h8000_0030, 32'h3000_0001);
    push_ok(64'h8000_0034, 32'h3000_0002);
    push_ok(64'h8000_0038, 32'h3000_0003);
    flush = 1'b1; out_ready = 1'b1;
    set_in(1'b1, 64'h8000_0040, 32'h3000_0004);
    @(negedge clk);
    chk("flush_count_before", {61'h0, count}, 64'h3);
    chk("flush_out_valid", {63'h0, out_valid}, 64'h0);
    chk("flush_in_ready", {63'h0, in_ready}, 64'h0);
    cyc();
    sb.delete();
    flush = 1'b0;
    set_in(1'b0, 64'h0, 32'h0);
    @(negedge clk);
    chk("flush_count_after", {61'h0, count}, 64'h0);
    chk("flush_out_valid_after", {63'h0, out_valid}, 64'h0);
    cyc(); cyc();

    // Full plus pop: pop only, push accepted the next cycle.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_ok(64'h8000_0050 + 64'(4 * i), 32'h5000_0000 + 32'(i));
    out_ready = 1'b1;
    set_in(1'b1, 64'h8000_0060, 32'h5000_0004);
    @(negedge clk);
    chk("fpop_count", {61'h0, count}, 64'h4);
    chk("fpop_in_ready", {63'h0, in_ready}, 64'h0);
    cyc();
    begin
      ent_t e;
      e.pc = 64'h8000_0060; e.inst = 32'h5000_0004;
      sb.push_back(e);
    end
    @(negedge clk);
    chk("fpop_count_next", {61'h0, count}, 64'h3);
    chk("fpop_in_ready_next", {63'h0, in_ready}, 64'h1);
    cyc();
    set_in(1'b0, 64'h0, 32'h0);
    @(negedge clk);
    chk("fpop_count_pushpop", {61'h0, count}, 64'h3);
    cyc(); cyc(); cyc();
    @(negedge clk);
    chk("fpop_drained", {61'h0, count}, 64'h0);
    cyc();

    // Reset mid-operation drops stored entries.
    out_ready = 1'b0;
    push_ok(64'h8000_0070, 32'h7000_0001);
    push_ok(64'h8000_0074, 32'h7000_0002);
    set_in(1'b0, 64'h0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", {63'h0, out_valid}, 64'h0);
    cyc();
    sb.delete();
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_count", {61'h0, count}, 64'h0);
    cyc();

    // IF->ID latency on an empty queue.
    begin
      ent_t e;
      e.pc = 64'h8000_0100; e.inst = 32'h0000_0513;
      sb.push_back(e);
    end
    set_in(1'b1, 64'h8000_0100, 32'h0000_0513);
    @(negedge clk);
`ifdef INST_QUEUE_BYPASS_EN
    chk("byp_out_valid", {63'h0, out_valid}, 64'h1);
    chk("byp_out_pc", out_pc, 64'h8000_0100);
    chk("byp_count", {61'h0, count}, 64'h0);
`else
    chk("lat_out_valid_same", {63'h0, out_valid}, 64'h0);
    chk("lat_count_same", {61'h0, count}, 64'h0);
`endif
    cyc();
    set_in(1'b0, 64'h0, 32'h0);
    @(negedge clk);
`ifdef INST_QUEUE_BYPASS_EN
    chk("byp_count_next", {61'h0, count}, 64'h0);
    chk("byp_out_valid_next", {63'h0, out_valid}, 64'h0);
`else
    chk("lat_out_valid_next", {63'h0, out_valid}, 64'h1);
    chk("lat_out_pc_next", out_pc, 64'h8000_0100);
    chk("lat_count_next", {61'h0, count}, 64'h1);
`endif
    cyc();
    @(negedge clk);
    chk("final_count", {61'h0, count}, 64'h0);
    chk("sb_empty", 64'(sb.size()), 64'h0);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
